// File: rtl/reg_readout_if.sv
// Parallel-capture / serial-readout bus between a requester and reg_readout.
// The master drives req, D and sready; the slave returns the serial stream and status.
interface reg_readout_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req;
  logic [WIDTH-1:0] D;
  logic             sready;
  logic             sout;
  logic             svalid;
  logic             busy;
  logic             done;

  modport master (
    output req, D, sready,
    input  sout, svalid, busy, done
  );

  modport slave (
    input  req, D, sready,
    output sout, svalid, busy, done
  );
endinterface

// File: rtl/reg_readout.sv
// Captures a parallel word on request and streams it MSB first over a valid/ready
// serial link, followed by an even-parity bit and a one-cycle done pulse.
module reg_readout #(
  parameter int unsigned WIDTH = 32
) (
  input logic         clk,
  input logic         reset,
  reg_readout_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StShift, StParity, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               parity_q, parity_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      shreg_q  <= '0;
      cnt_q    <= '0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      parity_q <= parity_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    parity_d = parity_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req) begin
          shreg_d  = bus.D;
          cnt_d    = CntW'(WIDTH);
          parity_d = ^bus.D;
          state_d  = StShift;
        end
      end
      StShift: begin
        // svalid is always high here, so sready alone qualifies the transfer.
        if (bus.sready) begin
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) state_d = StParity;
        end
      end
      StParity: begin
        if (bus.sready) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    bus.sout   = 1'b0;
    bus.svalid = 1'b0;
    bus.done   = 1'b0;
    bus.busy   = (state_q != StIdle);
    unique case (state_q)
      StShift: begin
        bus.svalid = 1'b1;
        bus.sout   = shreg_q[WIDTH-1];
      end
      StParity: begin
        bus.svalid = 1'b1;
        bus.sout   = parity_q;
      end
      StDone: begin
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_readout.sv
// Directed bench for reg_readout: latency, parity, back-pressure, reset abort and
// request-while-busy scenarios, each with hand-computed expectations.
module tb_reg_readout;

  logic clk;
  logic reset;

  reg_readout_if #(.WIDTH(32)) bus ();

  reg_readout #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Per-run observation logs, indexed by cycle number after the accepting edge.
  logic sout_log   [0:63];
  logic svalid_log [0:63];
  logic busy_log   [0:63];
  logic bits       [0:63];
  int   nbits;
  int   done_cnt;
  int   done_cyc;

  // Accepts d0 at edge 0, then runs ncyc cycles; req is held with req_d during
  // cycles req_lo..req_hi, sready is low in stall_lo..stall_hi, reset is high in rst_cyc.
  task automatic run(input logic [31:0] d0, input logic [31:0] d_after,
                     input logic [31:0] req_d, input int req_lo, input int req_hi,
                     input int stall_lo, input int stall_hi, input int rst_cyc,
                     input int ncyc);
    nbits    = 0;
    done_cnt = 0;
    done_cyc = -1;
    for (int i = 0; i < 64; i++) begin
      sout_log[i]   = 1'b0;
      svalid_log[i] = 1'b0;
      busy_log[i]   = 1'b0;
      bits[i]       = 1'b0;
    end
    @(negedge clk);
    reset      = 1'b0;
    bus.req    = 1'b1;
    bus.D      = d0;
    bus.sready = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= ncyc; c++) begin
      bus.req    = (c >= req_lo && c <= req_hi);
      bus.D      = (c >= req_lo && c <= req_hi) ? req_d : d_after;
      bus.sready = !(c >= stall_lo && c <= stall_hi);
      reset      = (c == rst_cyc);
      @(negedge clk);
      sout_log[c]   = bus.sout;
      svalid_log[c] = bus.svalid;
      busy_log[c]   = bus.busy;
      if (bus.svalid && bus.sready && nbits < 64) begin
        bits[nbits] = bus.sout;
        nbits++;
      end
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      @(posedge clk);
      #1;
    end
    bus.req    = 1'b0;
    bus.sready = 1'b1;
    reset      = 1'b0;
  endtask

  function automatic logic [31:0] word_of_bits();
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 32; i++) w = {w[30:0], bits[i]};
    return w;
  endfunction

  task automatic test_reset();
    reset      = 1'b1;
    bus.req    = 1'b1;
    bus.D      = 32'hFFFF_FFFF;
    bus.sready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy);
    end
    checks++;
    if (bus.svalid !== 1'b0) begin
      errors++; $display("FAIL reset_svalid: got %b expected 0", bus.svalid);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      errors++; $display("FAIL reset_done: got %b expected 0", bus.done);
    end
    checks++;
    if (bus.sout !== 1'b0) begin
      errors++; $display("FAIL reset_sout: got %b expected 0", bus.sout);
    end
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    reset   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    run(32'h8000_0001, 32'h8000_0001, 32'h0, 0, -1, 0, -1, -1, 37);
    checks++;
    if (svalid_log[1] !== 1'b1 || sout_log[1] !== 1'b1) begin
      errors++; $display("FAIL basic_first_bit: svalid=%b sout=%b expected 1 1",
                         svalid_log[1], sout_log[1]);
    end
    checks++;
    if (sout_log[2] !== 1'b0) begin
      errors++; $display("FAIL basic_second_bit: got %b expected 0", sout_log[2]);
    end
    checks++;
    if (nbits !== 33) begin
      errors++; $display("FAIL basic_nbits: got %0d expected 33", nbits);
    end
    checks++;
    if (word_of_bits() !== 32'h8000_0001) begin
      errors++; $display("FAIL basic_word: got %h expected 80000001", word_of_bits());
    end
    checks++;
    if (bits[32] !== 1'b0) begin
      errors++; $display("FAIL basic_parity: got %b expected 0", bits[32]);
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== 34) begin
      errors++; $display("FAIL basic_done: count=%0d cycle=%0d expected 1 at 34",
                         done_cnt, done_cyc);
    end
    checks++;
    if (svalid_log[34] !== 1'b0 || busy_log[34] !== 1'b1 || busy_log[35] !== 1'b0) begin
      errors++; $display("FAIL basic_done_flags: svalid34=%b busy34=%b busy35=%b expected 0 1 0",
                         svalid_log[34], busy_log[34], busy_log[35]);
    end
  endtask

  task automatic test_parity();
    logic [2:0] tail;
    run(32'h0000_0007, 32'h0000_0007, 32'h0, 0, -1, 0, -1, -1, 37);
    tail = {bits[29], bits[30], bits[31]};
    checks++;
    if (tail !== 3'b111 || word_of_bits() !== 32'h0000_0007) begin
      errors++; $display("FAIL parity_word: got %h tail %b expected 00000007 tail 111",
                         word_of_bits(), tail);
    end
    checks++;
    if (bits[32] !== 1'b1) begin
      errors++; $display("FAIL parity_bit: got %b expected 1", bits[32]);
    end
    checks++;
    if (done_cyc !== 34) begin
      errors++; $display("FAIL parity_done_cycle: got %0d expected 34", done_cyc);
    end
  endtask

  task automatic test_stall();
    run(32'hFFFF_0000, 32'hFFFF_0000, 32'h0, 0, -1, 5, 9, -1, 42);
    for (int c = 5; c <= 9; c++) begin
      checks++;
      if (svalid_log[c] !== 1'b1 || sout_log[c] !== 1'b1) begin
        errors++; $display("FAIL stall_hold_c%0d: svalid=%b sout=%b expected 1 1",
                           c, svalid_log[c], sout_log[c]);
      end
    end
    checks++;
    if (word_of_bits() !== 32'hFFFF_0000 || bits[32] !== 1'b0 || nbits !== 33) begin
      errors++; $display("FAIL stall_word: got %h parity %b nbits %0d expected ffff0000 0 33",
                         word_of_bits(), bits[32], nbits);
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== 39) begin
      errors++; $display("FAIL stall_done: count=%0d cycle=%0d expected 1 at 39",
                         done_cnt, done_cyc);
    end
  endtask

  task automatic test_reset_mid();
    int busy_cycles;
    run(32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h5555_5555, 10, 10, 0, -1, 10, 40);
    checks++;
    if (busy_log[11] !== 1'b0 || svalid_log[11] !== 1'b0 || sout_log[11] !== 1'b0) begin
      errors++; $display("FAIL rstmid_idle: busy=%b svalid=%b sout=%b expected 0 0 0",
                         busy_log[11], svalid_log[11], sout_log[11]);
    end
    busy_cycles = 0;
    for (int c = 11; c <= 40; c++) if (busy_log[c] !== 1'b0) busy_cycles++;
    checks++;
    if (busy_cycles !== 0) begin
      errors++; $display("FAIL rstmid_stays_idle: busy cycles=%0d expected 0", busy_cycles);
    end
    checks++;
    if (done_cnt !== 0) begin
      errors++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", done_cnt);
    end
    run(32'h0000_FFFF, 32'h0000_FFFF, 32'h0, 0, -1, 0, -1, -1, 37);
    checks++;
    if (word_of_bits() !== 32'h0000_FFFF || bits[32] !== 1'b0) begin
      errors++; $display("FAIL rstmid_fresh_word: got %h parity %b expected 0000ffff 0",
                         word_of_bits(), bits[32]);
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== 34) begin
      errors++; $display("FAIL rstmid_fresh_done: count=%0d cycle=%0d expected 1 at 34",
                         done_cnt, done_cyc);
    end
  endtask

  task automatic test_back_to_back();
    int busy_cycles;
    // req held from cycle 3 through the DONE cycle 34 with a different word.
    run(32'h0000_F00F, 32'hFFFF_FFFF, 32'h1234_5678, 3, 34, 0, -1, -1, 40);
    checks++;
    if (word_of_bits() !== 32'h0000_F00F || bits[32] !== 1'b0 || nbits !== 33) begin
      errors++; $display("FAIL b2b_word: got %h parity %b nbits %0d expected 0000f00f 0 33",
                         word_of_bits(), bits[32], nbits);
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== 34) begin
      errors++; $display("FAIL b2b_done: count=%0d cycle=%0d expected 1 at 34",
                         done_cnt, done_cyc);
    end
    busy_cycles = 0;
    for (int c = 35; c <= 40; c++) if (busy_log[c] !== 1'b0) busy_cycles++;
    checks++;
    if (busy_cycles !== 0) begin
      errors++; $display("FAIL b2b_req_ignored: busy cycles after done=%0d expected 0",
                         busy_cycles);
    end
  endtask

  initial begin
    reset      = 1'b1;
    bus.req    = 1'b0;
    bus.D      = '0;
    bus.sready = 1'b1;
    test_reset();
    test_basic();
    test_parity();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_readout.md
REG_READOUT -- requirements
Module: reg_readout

Interface
REQ-001 Parameter WIDTH, default 32: bit width of the captured register word.
REQ-002 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 Port req  input  1  request to capture D and begin serial readout.
REQ-005 Port D  input  WIDTH  parallel word to read, typically a register Q bus.
REQ-006 Port sready  input  1  downstream ready for the current serial bit.
REQ-007 Port sout  output  1  serial data bit.
REQ-008 Port svalid  output  1  sout holds a valid bit.
REQ-009 Port busy  output  1  readout in progress; new req not accepted.
REQ-010 Port done  output  1  one-cycle pulse after the final bit transfers.

Function
REQ-011 The block SHALL implement states IDLE, SHIFT, PARITY and DONE.
REQ-012 In IDLE with req=1 at a rising edge, the block SHALL capture D into a shift register, load the bit counter with WIDTH, compute even parity (XOR of all D bits), and enter SHIFT.
REQ-013 Captured data SHALL be unaffected by later changes on D until the next accepted req.
REQ-014 In SHIFT, the block SHALL drive svalid=1 and sout=MSB of the shift register, sending MSB first.
REQ-015 A bit SHALL transfer only on an edge where svalid=1 and sready=1; on transfer the shift register SHALL shift left by one and the counter SHALL decrement.
REQ-016 With sready=0, sout and svalid SHALL hold their values with no state change.
REQ-017 When the last data bit transfers (counter at 1), the block SHALL enter PARITY.
REQ-018 In PARITY, the block SHALL drive svalid=1 and sout=parity bit, so the total count of 1s over WIDTH+1 bits is even.
REQ-019 Parity transfer SHALL obey the REQ-015/016 handshake; on transfer the block SHALL enter DONE.
REQ-020 In DONE, done SHALL be 1 and svalid 0 for exactly one cycle; the next state SHALL be IDLE unconditionally.
REQ-021 busy SHALL be 1 in SHIFT, PARITY and DONE, and 0 in IDLE.
REQ-022 req SHALL be ignored in any state other than IDLE, including req asserted during DONE.
REQ-023 svalid, done and sout SHALL be 0 in IDLE.
REQ-024 Latency: req accepted at edge n gives svalid=1 in cycle n+1; with sready held at 1, done=1 in cycle n+WIDTH+2.
REQ-025 The counter SHALL be wide enough to hold WIDTH, and no wrap-around SHALL occur.

Reset
REQ-026 reset=1 at a rising edge SHALL force IDLE and clear the shift register, counter and parity, giving sout=0, svalid=0, busy=0 and done=0.
REQ-027 reset SHALL take priority over req and over any handshake in the same cycle.
REQ-028 reset mid-readout SHALL abort with no done pulse, and the partial word SHALL be discarded.

Verification
REQ-029 D=0x80000001, req pulse at edge 0, sready=1 always -> sout: 1, thirty 0s, 1, then parity 0; done=1 in cycle 34 only.
REQ-030 D=0x00000007, sready=1 -> last three data bits 1,1,1, parity bit 1, total ones 4.
REQ-031 D=0xFFFF0000, sready=0 in cycles 5-9 -> sout/svalid frozen for those cycles; sequence otherwise intact; done in cycle 39.
REQ-032 Reset during SHIFT (cycle 10, with req=1 simultaneously) -> next cycle IDLE, busy=0, svalid=0, no done pulse; fresh req of 0x0000FFFF then reads out correctly.
REQ-033 req repulsed with D=0x12345678 during busy, and D changed to 0xFFFFFFFF after capture of 0x0000F00F -> serial output equals 0x0000F00F with parity 0, a single done pulse, and the second req ignored.
